// File: rtl/fir_mac_engine.sv
// fir_mac_engine: pipelined signed multiply-accumulate engine for the FIR datapath.
// Each frame takes NTAPS (sample, coefficient) pairs over a valid/ready handshake.
// The products are summed at full precision. One result is held per frame until
// it is popped: the full sum, plus a rounded, shifted and optionally saturated copy.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clear               synchronous frame abort; flushes the pipeline, the accumulator and the counters
//   in_valid/in_ready   input handshake for inputX (signed sample) and inputB (signed coefficient)
//   out_valid/out_ready output handshake
//   accOut              full-precision frame sum (signed, ACC_W bits)
//   sumOut              rounded/shifted/saturated frame sum (signed, OUT_W bits)
//   sat                 sumOut was clipped (meaningful while out_valid is high)
module fir_mac_engine #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 39,
  parameter int NTAPS  = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] inputX,
  input  logic [COEF_W-1:0] inputB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  accOut,
  output logic [OUT_W-1:0]  sumOut,
  output logic              sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(NTAPS + 1);
  localparam logic [CNT_W-1:0] NTAPS_C  = CNT_W'(NTAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  if (NTAPS < 1) begin : g_bad_ntaps
    $error("fir_mac_engine: NTAPS must be >= 1");
  end
  if (ACC_W < DATA_W + COEF_W + $clog2(NTAPS)) begin : g_bad_acc_w
    $error("fir_mac_engine: ACC_W too narrow for DATA_W+COEF_W+clog2(NTAPS)");
  end
  if (OUT_W > ACC_W) begin : g_bad_out_w
    $error("fir_mac_engine: OUT_W must not exceed ACC_W");
  end
  if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_bad_shift
    $error("fir_mac_engine: SHIFT out of range");
  end

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         accept_cnt;
  logic [CNT_W-1:0]         tap_cnt;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_v;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     fin_v;
  logic [OUT_W-1:0]         sum_out;

  logic                     accept;
  logic                     last_add;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic [OUT_W-1:0]         sum_n;
  logic                     sat_n;

  // rst_n gates in_ready so that no pair is offered as accepted while reset is held.
  assign in_ready = rst_n && (state == ACCUM) && (accept_cnt < NTAPS_C);
  assign accept   = in_valid && in_ready && !clear;
  assign last_add = prod_v && (tap_cnt == LAST_TAP);
  assign prod_ext = ACC_W'(prod);

  assign accOut = acc_out;
  assign sumOut = sum_out;

  always_comb begin
    rnd_sum = (ACC_W+1)'(acc_out) + RND;
    shifted = rnd_sum >>> SHIFT;
    sum_n   = shifted[OUT_W-1:0];
    sat_n   = 1'b0;
    if (SAT_EN != 0) begin
      if (shifted > SAT_MAX) begin
        sum_n = SAT_MAX[OUT_W-1:0];
        sat_n = 1'b1;
      end else if (shifted < SAT_MIN) begin
        sum_n = SAT_MIN[OUT_W-1:0];
        sat_n = 1'b1;
      end
    end
  end

  // Final add (fin_v) and rounding register are separate stages, so HOLD is
  // entered one edge after the last product lands in acc_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      accept_cnt <= '0;
      tap_cnt    <= '0;
      prod       <= '0;
      prod_v     <= 1'b0;
      acc        <= '0;
      acc_out    <= '0;
      fin_v      <= 1'b0;
      sum_out    <= '0;
      sat        <= 1'b0;
      out_valid  <= 1'b0;
    end else if (clear) begin
      state      <= ACCUM;
      accept_cnt <= '0;
      tap_cnt    <= '0;
      prod_v     <= 1'b0;
      acc        <= '0;
      fin_v      <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod       <= $signed(inputX) * $signed(inputB);
        accept_cnt <= accept_cnt + 1'b1;
      end

      if (prod_v) begin
        if (tap_cnt == LAST_TAP) begin
          acc_out <= acc + prod_ext;
          acc     <= '0;
          tap_cnt <= '0;
        end else begin
          acc     <= acc + prod_ext;
          tap_cnt <= tap_cnt + 1'b1;
        end
      end

      fin_v <= last_add;
      if (fin_v) begin
        sum_out <= sum_n;
        sat     <= sat_n;
      end

      case (state)
        ACCUM: if (accept && accept_cnt == LAST_TAP) state <= DRAIN;
        DRAIN: if (fin_v) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) begin
          state      <= ACCUM;
          out_valid  <= 1'b0;
          accept_cnt <= '0;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
module tb_fir_mac_engine;

  // Instances: 0: NTAPS=4 SHIFT=0 SAT; 1: NTAPS=4 SHIFT=15 SAT; 2: NTAPS=4 SHIFT=15 wrap;
  //            3: NTAPS=1 SHIFT=15 SAT; 4: NTAPS=16 SHIFT=15 SAT
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  iv = '0;
  logic [4:0]  orv = '0;
  logic [15:0] X = '0;
  logic [15:0] B = '0;
  logic [4:0]  ir;
  logic [4:0]  ov;
  logic [4:0]  sat_o;
  logic [38:0] acc_o [5];
  logic [15:0] sum_o [5];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_mac_engine #(.NTAPS(4), .SHIFT(0), .SAT_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
    .inputX(X), .inputB(B), .out_valid(ov[0]), .out_ready(orv[0]),
    .accOut(acc_o[0]), .sumOut(sum_o[0]), .sat(sat_o[0]));
  fir_mac_engine #(.NTAPS(4), .SHIFT(15), .SAT_EN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
    .inputX(X), .inputB(B), .out_valid(ov[1]), .out_ready(orv[1]),
    .accOut(acc_o[1]), .sumOut(sum_o[1]), .sat(sat_o[1]));
  fir_mac_engine #(.NTAPS(4), .SHIFT(15), .SAT_EN(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]),
    .inputX(X), .inputB(B), .out_valid(ov[2]), .out_ready(orv[2]),
    .accOut(acc_o[2]), .sumOut(sum_o[2]), .sat(sat_o[2]));
  fir_mac_engine #(.NTAPS(1), .SHIFT(15), .SAT_EN(1)) u_d (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[3]), .in_ready(ir[3]),
    .inputX(X), .inputB(B), .out_valid(ov[3]), .out_ready(orv[3]),
    .accOut(acc_o[3]), .sumOut(sum_o[3]), .sat(sat_o[3]));
  fir_mac_engine #(.NTAPS(16), .SHIFT(15), .SAT_EN(1)) u_e (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[4]), .in_ready(ir[4]),
    .inputX(X), .inputB(B), .out_valid(ov[4]), .out_ready(orv[4]),
    .accOut(acc_o[4]), .sumOut(sum_o[4]), .sat(sat_o[4]));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one pair to the instances in mask m; returns #1 after the accepting edge.
  task automatic push(input logic [4:0] m, input int x, input int b);
    int n;
    n = 0;
    @(negedge clk);
    iv = m; X = 16'(x); B = 16'(b);
    while ((ir & m) != m && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {59'd0, ir & m}, {59'd0, m});
    @(posedge clk); #1;
    iv = '0;
  endtask

  task automatic wait_ov(input int d);
    int n;
    n = 0;
    while (!ov[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_wait", {63'd0, ov[d]}, 64'sd1);
  endtask

  task automatic pop(input logic [4:0] m);
    @(negedge clk);
    orv = m;
    @(posedge clk); #1;
    orv = '0;
  endtask

  task automatic chk_res(input string tag, input int d, input longint ea, input longint es, input logic esat);
    chk({tag, "_acc"}, $signed(acc_o[d]), ea);
    chk({tag, "_sum"}, $signed(sum_o[d]), es);
    chk({tag, "_sat"}, {63'd0, sat_o[d]}, {63'd0, esat});
  endtask

  initial begin
    int rx [4];
    int rb [4];
    int rs [4];
    longint s, r, es;
    logic esat;
    int x, b;
    time t0, t1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, ir[0]}, 64'sd0);
    chk("rst_out_valid", {59'd0, ov}, 64'sd0);
    chk_res("rst", 4, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {59'd0, ir}, 64'sd31);

    // Basic frame and latency: out_valid rises two edges after the 4th accept
    push(5'b00001, 1, 2);
    push(5'b00001, 2, 2);
    push(5'b00001, 3, 2);
    push(5'b00001, 4, 2);
    chk("lat_k", {63'd0, ov[0]}, 64'sd0);
    @(posedge clk); #1;
    chk("lat_k1", {63'd0, ov[0]}, 64'sd0);
    @(posedge clk); #1;
    chk("lat_k2", {63'd0, ov[0]}, 64'sd1);
    chk_res("basic", 0, 20, 20, 1'b0);
    pop(5'b00001);

    // Saturation vs wrap on the same frame
    repeat (4) push(5'b00110, 16384, 16384);
    wait_ov(1);
    chk("wrap_ov", {63'd0, ov[2]}, 64'sd1);
    chk_res("satur", 1, 64'sd1073741824, 32767, 1'b1);
    chk_res("wrap", 2, 64'sd1073741824, -32768, 1'b0);
    pop(5'b00110);

    // Round half up at SHIFT=15, NTAPS=1
    rx = '{1, 1, -1, -1};
    rb = '{16384, 16383, 16384, 16385};
    rs = '{1, 0, 0, -1};
    for (int unsigned i = 0; i < 4; i++) begin
      push(5'b01000, rx[i], rb[i]);
      wait_ov(3);
      chk_res("round", 3, longint'(rx[i]) * rb[i], rs[i], 1'b0);
      pop(5'b01000);
    end

    // Back-pressure: result held stable, no accepts during HOLD
    for (int i = 5; i <= 8; i++) push(5'b00001, i, -1);
    wait_ov(0);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_in_ready", {63'd0, ir[0]}, 64'sd0);
      chk("bp_out_valid", {63'd0, ov[0]}, 64'sd1);
      chk_res("bp_hold", 0, -26, -26, 1'b0);
      @(posedge clk); #1;
    end
    pop(5'b00001);
    chk("pop_out_valid", {63'd0, ov[0]}, 64'sd0);
    chk("pop_in_ready", {63'd0, ir[0]}, 64'sd1);
    chk_res("pop_keep", 0, -26, -26, 1'b0);
    repeat (4) push(5'b00001, 1, 3);
    wait_ov(0);
    chk_res("bp_next", 0, 12, 12, 1'b0);
    pop(5'b00001);

    // NTAPS=16 extreme products and 1 pair/cycle throughput
    push(5'b10000, -32768, -32768);
    t0 = $time;
    repeat (15) push(5'b10000, -32768, -32768);
    t1 = $time;
    chk("throughput", longint'(t1 - t0), 150);
    wait_ov(4);
    chk_res("max16", 4, 64'sd17179869184, 32767, 1'b1);
    pop(5'b10000);

    // Random frames against an arithmetic model
    for (int unsigned f = 0; f < 200; f++) begin
      s = 0;
      for (int unsigned t = 0; t < 16; t++) begin
        x = int'($urandom_range(65535, 0)) - 32768;
        b = int'($urandom_range(65535, 0)) - 32768;
        s += longint'(x) * longint'(b);
        push(5'b10000, x, b);
      end
      wait_ov(4);
      r = (s + 16384) >>> 15;
      esat = 1'b0;
      es = r;
      if (r > 32767) begin es = 32767; esat = 1'b1; end
      else if (r < -32768) begin es = -32768; esat = 1'b1; end
      chk_res("rand", 4, s, es, esat);
      pop(5'b10000);
    end

    // clear after two accepts, with a pair presented alongside clear
    push(5'b00001, 100, 1);
    push(5'b00001, 200, 1);
    @(negedge clk);
    iv = 5'b00001; X = 16'd50; B = 16'd1; clear = 1'b1;
    @(posedge clk); #1;
    iv = '0; clear = 1'b0;
    chk("clr_in_ready", {63'd0, ir[0]}, 64'sd1);
    repeat (4) push(5'b00001, 3, 1);
    wait_ov(0);
    chk_res("clr_frame", 0, 12, 12, 1'b0);
    pop(5'b00001);

    // clear during HOLD drops the result
    repeat (4) push(5'b00001, 9, 1);
    wait_ov(0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_hold_ov", {63'd0, ov[0]}, 64'sd0);
    chk("clr_hold_rdy", {63'd0, ir[0]}, 64'sd1);
    repeat (4) push(5'b00001, 3, 1);
    wait_ov(0);
    chk_res("clr_hold_next", 0, 12, 12, 1'b0);

    // Asynchronous reset mid-frame
    pop(5'b00001);
    push(5'b00001, 7, 7);
    push(5'b00001, 7, 7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, ir[0]}, 64'sd0);
    chk("arst_out_valid", {59'd0, ov}, 64'sd0);
    chk_res("arst_a", 0, 0, 0, 1'b0);
    chk_res("arst_b", 1, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release_rdy", {63'd0, ir[0]}, 64'sd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
